// File: rtl/ram_burst_master.sv
// ---------------------------------------------------------------------------
// ram_burst_master
//
// Burst initiator for a single-port block RAM (synchronous read, one-cycle
// latency, no output register). A command gives a start address, a byte
// count and a direction. A write burst streams bytes from the wr_* handshake
// into the RAM. A read burst streams RAM bytes out through a 3-entry FIFO on
// the rd_* handshake. The read path handles backpressure and sustains one
// byte per cycle.
//
// Ports:
//   clk, RST              single clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_write/addr/len    burst direction, start address, byte count (0 ok)
//   wr_data/valid/ready   write byte stream into the RAM
//   rd_data/valid/ready   read byte stream out of the RAM
//   busy                  high whenever a burst is in progress
//   done                  one-cycle pulse when a burst completes
//   ram_addr/di/en/we     RAM port drive; both ram_we bits always equal
//   ram_regce, ram_rst    tied low
//   ram_do                RAM read data, valid the cycle after a read issue
// ---------------------------------------------------------------------------
module ram_burst_master #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  output logic              ram_en,
  output logic [1:0]        ram_we,
  output logic              ram_regce,
  output logic              ram_rst,
  input  logic [DATA_W-1:0] ram_do
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              inflight_q, inflight_d;

  logic [DATA_W-1:0] fifo_mem_q [3];
  logic [DATA_W-1:0] fifo_mem_d [3];
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  logic              push;
  logic              pop;
  logic              issue;
  logic              we_bit;
  logic [2:0]        credits_used;

  // Read credit: a FIFO slot is reserved for every byte already buffered and
  // for the byte whose read was issued last cycle, so the FIFO cannot
  // overflow. A pop in the current cycle is deliberately not counted as a
  // freed slot; with a steady consumer the loop still settles at one buffered
  // byte plus one in flight, which keeps full throughput.
  always_comb begin
    credits_used = {1'b0, count_q} + {2'b00, inflight_q};
    push         = inflight_q;
    pop          = (count_q != 2'd0) && rd_ready;
    issue        = (state_q == READ) && (credits_used < 3'd3);
  end

  // FIFO next-state: ram_do is captured on the cycle after an issue; push and
  // pop in the same cycle are both honoured and leave the count unchanged.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = ram_do;
      wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Main FSM next-state and output decode. RAM drive values are forced to
  // zero except on a cycle that actually accesses the RAM, which also gives
  // the all-zero outputs required while reset holds the FSM in IDLE.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    inflight_d  = issue;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    ram_en      = 1'b0;
    we_bit      = 1'b0;
    ram_addr    = '0;
    ram_di      = '0;

    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_addr_d  = cmd_addr;
          remaining_d = cmd_len;
          if (cmd_len == '0) begin
            state_d = DONE;
          end else if (cmd_write) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end

      WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          ram_en      = 1'b1;
          we_bit      = 1'b1;
          ram_addr    = cur_addr_q;
          ram_di      = wr_data;
          cur_addr_d  = cur_addr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end

      READ: begin
        if (issue) begin
          ram_en      = 1'b1;
          ram_addr    = cur_addr_q;
          cur_addr_d  = cur_addr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Leave as the last byte is popped (FIFO empty after this cycle and
        // nothing in flight) so done pulses the cycle after that handshake.
        if (!inflight_q && (count_d == 2'd0)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read-side outputs come straight from the FIFO head.
  always_comb begin
    rd_valid  = (count_q != 2'd0);
    rd_data   = rd_valid ? fifo_mem_q[rd_ptr_q] : '0;
    ram_we    = {2{we_bit}};
    ram_regce = 1'b0;
    ram_rst   = 1'b0;
  end

  // State registers. Reset discards any buffered or in-flight read data.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      inflight_q    <= 1'b0;
      wr_ptr_q      <= 2'd0;
      rd_ptr_q      <= 2'd0;
      count_q       <= 2'd0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      fifo_mem_q[2] <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_mem_q  <= fifo_mem_d;
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// ---------------------------------------------------------------------------
// tb_ram_burst_master
//
// Directed bench for ram_burst_master with a behavioural model of the block
// RAM attached. Inputs change 1 time unit after a rising edge; outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ram_burst_master;

   logic        clk = 1'b0;
   logic        RST;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [14:0] cmd_addr;
   logic [15:0] cmd_len;
   logic [7:0]  wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic        busy;
   logic        done;
   logic [14:0] ram_addr;
   logic [7:0]  ram_di;
   logic        ram_en;
   logic [1:0]  ram_we;
   logic        ram_regce;
   logic        ram_rst;
   logic [7:0]  ram_do;

   int errors = 0;
   int checks = 0;

   // Results handed back by the stimulus helpers
   int         wrSent;
   logic       wrDoneAfter;
   logic [7:0] rdGot [0:15];
   int         rdCount;
   int         rdFirst;
   int         rdStallIssues;
   logic       rdGap;
   logic       rdDoneAfter;

   // Activity monitor counters
   int          enCount = 0;
   int          weCount = 0;
   int          doneCount = 0;
   logic        tieBad = 1'b0;
   logic [14:0] accLog [0:511];
   logic [8:0]  accIdx = 9'd0;

   logic [7:0]  ramMem [0:32767];

   ram_burst_master dut (
      .clk       (clk),
      .RST       (RST),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .busy      (busy),
      .done      (done),
      .ram_addr  (ram_addr),
      .ram_di    (ram_di),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_regce (ram_regce),
      .ram_rst   (ram_rst),
      .ram_do    (ram_do)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   // Block RAM model: synchronous read with one cycle of latency
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we[0]) ramMem[ram_addr] <= ram_di;
         ram_do <= ramMem[ram_addr];
      end
   end

   // Records every RAM access, write-enable cycles, done pulses and tie-offs
   always @(negedge clk) begin
      if (ram_en) begin
         enCount <= enCount + 1;
         accLog[accIdx] <= ram_addr;
         accIdx <= accIdx + 9'd1;
      end
      if (ram_we != 2'b00) weCount <= weCount + 1;
      if (done) doneCount <= doneCount + 1;
      if (ram_we[0] !== ram_we[1] || ram_regce !== 1'b0 || ram_rst !== 1'b0) tieBad <= 1'b1;
   end

   // Absolute time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Offers a command and waits (bounded) for its handshake; returns one
   // time unit after the accepting edge
   task automatic startCmd(input logic w, input logic [14:0] a, input logic [15:0] l, output logic ok);
      ok = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_len   = l;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
   endtask

   // Streams n bytes base, base+1, ... and samples done the cycle after the
   // final handshake
   task automatic writeBytes(input logic [7:0] base, input int n);
      int cyc;
      cyc = 0;
      wrSent = 0;
      wr_valid = 1'b1;
      wr_data = base;
      while (wrSent < n && cyc < 100) begin
         @(negedge clk);
         if (wr_ready) begin
            @(posedge clk); #1;
            wrSent++;
            wr_data = base + 8'(wrSent);
         end else begin
            @(posedge clk); #1;
         end
         cyc++;
      end
      wr_valid = 1'b0;
      @(negedge clk);
      wrDoneAfter = done;
      @(posedge clk); #1;
   endtask

   // Collects n read bytes, holding rd_ready low for the first stall cycles
   // (cycle 1 is the cycle after the command handshake)
   task automatic readBytes(input int n, input int stall);
      int cyc;
      cyc = 1;
      rdCount = 0;
      rdFirst = -1;
      rdStallIssues = 0;
      rdGap = 1'b0;
      rd_ready = (stall == 0);
      while (rdCount < n && cyc < 200) begin
         if (cyc > stall) rd_ready = 1'b1;
         @(negedge clk);
         if (cyc <= stall && ram_en) rdStallIssues++;
         if (rd_valid && rdFirst < 0) rdFirst = cyc;
         if (rd_valid && rd_ready) begin
            if (rdCount < 16) rdGot[rdCount] = rd_data;
            rdCount++;
         end else if (rdFirst >= 0) begin
            rdGap = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      rd_ready = 1'b0;
      @(negedge clk);
      rdDoneAfter = done;
      @(posedge clk); #1;
   endtask

   // Output values while reset is held
   task automatic test_reset;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_ready: got %b expected 0", wr_ready); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", rd_valid); end
      checks++; if (ram_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_en: got %b expected 0", ram_en); end
      checks++; if (ram_we !== 2'b00) begin errors++; $display("[TB] FAIL reset_ram_we: got %b expected 00", ram_we); end
      checks++; if (ram_addr !== 15'h0000) begin errors++; $display("[TB] FAIL reset_ram_addr: got %h expected 0000", ram_addr); end
      checks++; if (ram_di !== 8'h00) begin errors++; $display("[TB] FAIL reset_ram_di: got %h expected 00", ram_di); end
      checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd_data: got %h expected 00", rd_data); end
   endtask

   // Write A0..A3 at 0x0010 and read them back
   task automatic test_write_read;
      logic ok;
      int weStart, doneStart;
      weStart = weCount;
      doneStart = doneCount;
      startCmd(1'b1, 15'h0010, 16'd4, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL wr_cmd_accept: got %b expected 1", ok); end
      writeBytes(8'hA0, 4);
      checks++; if (wrSent != 4) begin errors++; $display("[TB] FAIL wr_sent: got %0d expected 4", wrSent); end
      checks++; if (wrDoneAfter !== 1'b1) begin errors++; $display("[TB] FAIL wr_done_pulse: got %b expected 1", wrDoneAfter); end
      startCmd(1'b0, 15'h0010, 16'd4, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL rd_cmd_accept: got %b expected 1", ok); end
      readBytes(4, 0);
      checks++; if (rdCount != 4) begin errors++; $display("[TB] FAIL rd_count: got %0d expected 4", rdCount); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rdGot[k] !== 8'hA0 + 8'(k)) begin
            errors++; $display("[TB] FAIL rd_data[%0d]: got %h expected %h", k, rdGot[k], 8'hA0 + 8'(k));
         end
      end
      checks++; if (rdDoneAfter !== 1'b1) begin errors++; $display("[TB] FAIL rd_done_pulse: got %b expected 1", rdDoneAfter); end
      checks++; if (weCount - weStart != 4) begin errors++; $display("[TB] FAIL we_cycles: got %0d expected 4", weCount - weStart); end
      checks++; if (doneCount - doneStart != 2) begin errors++; $display("[TB] FAIL done_pulses: got %0d expected 2", doneCount - doneStart); end
   endtask

   // Eight-byte read with a consumer that is always ready
   task automatic test_read_stream;
      logic ok;
      startCmd(1'b1, 15'h0100, 16'd8, ok);
      writeBytes(8'hC0, 8);
      checks++; if (wrSent != 8) begin errors++; $display("[TB] FAIL stream_wr_sent: got %0d expected 8", wrSent); end
      startCmd(1'b0, 15'h0100, 16'd8, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL stream_cmd_accept: got %b expected 1", ok); end
      readBytes(8, 0);
      checks++; if (rdFirst != 3) begin errors++; $display("[TB] FAIL stream_first_valid: got cycle %0d expected 3", rdFirst); end
      checks++; if (rdGap !== 1'b0) begin errors++; $display("[TB] FAIL stream_bubble: got %b expected 0", rdGap); end
      checks++; if (rdCount != 8) begin errors++; $display("[TB] FAIL stream_count: got %0d expected 8", rdCount); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (rdGot[k] !== 8'hC0 + 8'(k)) begin
            errors++; $display("[TB] FAIL stream_data[%0d]: got %h expected %h", k, rdGot[k], 8'hC0 + 8'(k));
         end
      end
      checks++; if (rdDoneAfter !== 1'b1) begin errors++; $display("[TB] FAIL stream_done_pulse: got %b expected 1", rdDoneAfter); end
   endtask

   // Six-byte read with the consumer stalled for ten cycles
   task automatic test_backpressure;
      logic ok;
      startCmd(1'b1, 15'h0200, 16'd6, ok);
      writeBytes(8'h30, 6);
      startCmd(1'b0, 15'h0200, 16'd6, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL bp_cmd_accept: got %b expected 1", ok); end
      readBytes(6, 10);
      checks++; if (rdStallIssues != 3) begin errors++; $display("[TB] FAIL bp_stalled_issues: got %0d expected 3", rdStallIssues); end
      checks++; if (rdCount != 6) begin errors++; $display("[TB] FAIL bp_count: got %0d expected 6", rdCount); end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (rdGot[k] !== 8'h30 + 8'(k)) begin
            errors++; $display("[TB] FAIL bp_data[%0d]: got %h expected %h", k, rdGot[k], 8'h30 + 8'(k));
         end
      end
      checks++; if (rdDoneAfter !== 1'b1) begin errors++; $display("[TB] FAIL bp_done_pulse: got %b expected 1", rdDoneAfter); end
   endtask

   // Four bytes straddling the top of the address space
   task automatic test_wrap;
      logic ok;
      logic [8:0] idx0;
      logic [14:0] expAddr [4];
      expAddr = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
      idx0 = accIdx;
      startCmd(1'b1, 15'h7FFE, 16'd4, ok);
      writeBytes(8'h50, 4);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (accLog[idx0 + 9'(k)] !== expAddr[k]) begin
            errors++; $display("[TB] FAIL wrap_wr_addr[%0d]: got %h expected %h", k, accLog[idx0 + 9'(k)], expAddr[k]);
         end
      end
      idx0 = accIdx;
      startCmd(1'b0, 15'h7FFE, 16'd4, ok);
      readBytes(4, 0);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (accLog[idx0 + 9'(k)] !== expAddr[k]) begin
            errors++; $display("[TB] FAIL wrap_rd_addr[%0d]: got %h expected %h", k, accLog[idx0 + 9'(k)], expAddr[k]);
         end
         checks++;
         if (rdGot[k] !== 8'h50 + 8'(k)) begin
            errors++; $display("[TB] FAIL wrap_data[%0d]: got %h expected %h", k, rdGot[k], 8'h50 + 8'(k));
         end
      end
   endtask

   // Zero-length write and read commands
   task automatic test_zero_len;
      logic ok;
      int enStart;
      enStart = enCount;
      for (int d = 0; d < 2; d++) begin
         startCmd(d == 0, 15'h0040, 16'd0, ok);
         checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL zero_cmd_accept[%0d]: got %b expected 1", d, ok); end
         @(negedge clk);
         checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done[%0d]: got %b expected 1", d, done); end
         @(posedge clk); #1;
         @(negedge clk);
         checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL zero_back_idle[%0d]: got %b expected 1", d, cmd_ready); end
         @(posedge clk); #1;
      end
      checks++; if (enCount != enStart) begin errors++; $display("[TB] FAIL zero_ram_en: got %0d accesses expected 0", enCount - enStart); end
   endtask

   // Reset asserted after two of five read bytes have been delivered
   task automatic test_reset_mid_read;
      logic ok;
      int nGot, cyc, enStart;
      logic [7:0] b0, b1;
      b0 = 8'h00;
      b1 = 8'h00;
      startCmd(1'b0, 15'h0010, 16'd5, ok);
      rd_ready = 1'b1;
      nGot = 0;
      cyc = 0;
      while (nGot < 2 && cyc < 20) begin
         @(negedge clk);
         if (rd_valid) begin
            if (nGot == 0) b0 = rd_data; else b1 = rd_data;
            nGot++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      checks++; if (b0 !== 8'hA0 || b1 !== 8'hA1) begin errors++; $display("[TB] FAIL mid_pre_data: got %h %h expected a0 a1", b0, b1); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_busy: got %b expected 1", busy); end
      RST = 1'b1;
      #1;
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rd_valid: got %b expected 0", rd_valid); end
      checks++; if (ram_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_ram_en: got %b expected 0", ram_en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
      rd_ready = 1'b0;
      enStart = enCount;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (enCount != enStart) begin errors++; $display("[TB] FAIL mid_access_in_reset: got %0d expected 0", enCount - enStart); end
      RST = 1'b0;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_cmd_ready: got %b expected 1", cmd_ready); end
      @(posedge clk); #1;
      startCmd(1'b0, 15'h0012, 16'd2, ok);
      readBytes(2, 0);
      checks++; if (rdCount != 2) begin errors++; $display("[TB] FAIL mid_new_count: got %0d expected 2", rdCount); end
      checks++; if (rdGot[0] !== 8'hA2 || rdGot[1] !== 8'hA3) begin
         errors++; $display("[TB] FAIL mid_new_data: got %h %h expected a2 a3", rdGot[0], rdGot[1]);
      end
   endtask

   // Tie-offs and write-enable bit equality over the whole run
   task automatic test_ties;
      checks++; if (tieBad !== 1'b0) begin errors++; $display("[TB] FAIL tie_offs: got %b expected 0", tieBad); end
   endtask

   // Sequence of scenarios
   initial begin
      RST = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr = 15'h1234;
      cmd_len = 16'd0;
      wr_data = 8'h5A;
      wr_valid = 1'b1;
      rd_ready = 1'b0;
      #12;
      test_reset;
      wr_valid = 1'b0;
      @(posedge clk); #1;
      RST = 1'b0;
      @(posedge clk); #1;
      $display("[TB] reset released");
      test_write_read;
      test_read_stream;
      test_backpressure;
      test_wrap;
      test_zero_len;
      test_reset_mid_read;
      test_ties;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
